// File: rtl/scr1_pwr_seq_ctrl_pkg.sv
// scr1_pwr_seq_pkg: shared domain state type and default sizing for the power sequencer
package scr1_pwr_seq_pkg;
  typedef enum logic [2:0] {RST, REL, RUN, IDLE, SLEEP} type_scr1_pwr_dom_st_e;
  localparam int DOM_NUM_DEF     = 4;
  localparam int RST_STAGGER_DEF = 4;
  localparam int IDLE_THRESH_DEF = 16;
  localparam int CNT_W_DEF       = 6;
endpackage

// File: rtl/scr1_pwr_seq_ctrl_if.sv
// scr1_pwr_seq_ctrl_if: per-domain request and status bundle between the core top and the sequencer
interface scr1_pwr_seq_ctrl_if import scr1_pwr_seq_pkg::*; #(parameter int DOM_NUM = DOM_NUM_DEF);
  logic               test_mode;
  logic [DOM_NUM-1:0] dom_rst_req;
  logic [DOM_NUM-1:0] dom_busy;
  logic [DOM_NUM-1:0] dom_sleep_req;
  logic [DOM_NUM-1:0] dom_wake_req;
  logic [DOM_NUM-1:0] dom_rst_n;
  logic [DOM_NUM-1:0] dom_rst_sts;
  logic [DOM_NUM-1:0] dom_clk_en;
  logic [DOM_NUM-1:0] dom_sleeping;
  modport master (
    output test_mode, dom_rst_req, dom_busy, dom_sleep_req, dom_wake_req,
    input  dom_rst_n, dom_rst_sts, dom_clk_en, dom_sleeping
  );
  modport slave (
    input  test_mode, dom_rst_req, dom_busy, dom_sleep_req, dom_wake_req,
    output dom_rst_n, dom_rst_sts, dom_clk_en, dom_sleeping
  );
endinterface

// File: rtl/scr1_pwr_seq_ctrl_dom_fsm.sv
// scr1_pwr_dom_fsm: one domain's reset-release / idle-sleep state machine with its shared counter
module scr1_pwr_dom_fsm import scr1_pwr_seq_pkg::*; #(
  parameter int RST_STAGGER = RST_STAGGER_DEF,
  parameter int IDLE_THRESH = IDLE_THRESH_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_req,
  input  logic par_rst,
  input  logic busy,
  input  logic sleep_req,
  input  logic wake_req,
  output logic dom_rst_n,
  output logic dom_rst_sts,
  output logic dom_clk_en,
  output logic dom_sleeping
);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(RST_STAGGER - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_THRESH - 1);
  type_scr1_pwr_dom_st_e st;
  logic [CNT_W-1:0]      cnt;
  // state and counter; any reset source wins, counter is cleared on every state change
  always_ff @(posedge clk) begin
    if (!rst_n || rst_req || par_rst) begin
      st  <= RST;
      cnt <= '0;
    end else begin
      case (st)
        RST: begin
          st  <= REL;
          cnt <= '0;
        end
        REL: begin
          st  <= (cnt == REL_LAST) ? RUN : REL;
          cnt <= (cnt == REL_LAST) ? '0 : cnt + CNT_W'(1);
        end
        RUN: begin
          st  <= (sleep_req && !busy && !wake_req) ? IDLE : RUN;
          cnt <= '0;
        end
        IDLE: begin
          st  <= (busy || wake_req || !sleep_req) ? RUN : (cnt == IDLE_LAST) ? SLEEP : IDLE;
          cnt <= (busy || wake_req || !sleep_req || cnt == IDLE_LAST) ? '0 : cnt + CNT_W'(1);
        end
        SLEEP: begin
          st  <= (wake_req || busy) ? RUN : SLEEP;
          cnt <= '0;
        end
        default: begin
          st  <= RST;
          cnt <= '0;
        end
      endcase
    end
  end
  assign dom_rst_n    = st inside {RUN, IDLE, SLEEP};
  assign dom_rst_sts  = st inside {RST, REL};
  assign dom_clk_en   = st != SLEEP;
  assign dom_sleeping = st == SLEEP;
endmodule

// File: rtl/scr1_pwr_seq_ctrl.sv
// scr1_pwr_seq_ctrl: chained per-domain reset sequencing and clock gating with scan bypass
module scr1_pwr_seq_ctrl import scr1_pwr_seq_pkg::*; #(
  parameter int DOM_NUM     = DOM_NUM_DEF,
  parameter int RST_STAGGER = RST_STAGGER_DEF,
  parameter int IDLE_THRESH = IDLE_THRESH_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  scr1_pwr_seq_ctrl_if.slave  bus
);
  if (RST_STAGGER < 1 || RST_STAGGER > (1 << CNT_W)) begin : g_bad_stagger
    $error("RST_STAGGER must be in 1..2**CNT_W");
  end
  if (IDLE_THRESH < 1 || IDLE_THRESH > (1 << CNT_W)) begin : g_bad_idle
    $error("IDLE_THRESH must be in 1..2**CNT_W");
  end
  logic [DOM_NUM-1:0] fsm_rst_n;
  logic [DOM_NUM-1:0] fsm_rst_sts;
  logic [DOM_NUM-1:0] fsm_clk_en;
  logic [DOM_NUM-1:0] fsm_sleeping;
  logic [DOM_NUM-1:0] par_rst;
  // each domain is held while its parent's registered reset is active; domain 0 has no parent
  assign par_rst = ~DOM_NUM'({fsm_rst_n, 1'b1});
  for (genvar g = 0; g < DOM_NUM; g++) begin : g_dom
    scr1_pwr_dom_fsm #(
      .RST_STAGGER (RST_STAGGER),
      .IDLE_THRESH (IDLE_THRESH),
      .CNT_W       (CNT_W)
    ) u_fsm (
      .clk          (clk),
      .rst_n        (rst_n),
      .rst_req      (bus.dom_rst_req[g]),
      .par_rst      (par_rst[g]),
      .busy         (bus.dom_busy[g]),
      .sleep_req    (bus.dom_sleep_req[g]),
      .wake_req     (bus.dom_wake_req[g]),
      .dom_rst_n    (fsm_rst_n[g]),
      .dom_rst_sts  (fsm_rst_sts[g]),
      .dom_clk_en   (fsm_clk_en[g]),
      .dom_sleeping (fsm_sleeping[g])
    );
  end
  assign bus.dom_rst_n    = bus.test_mode ? {DOM_NUM{rst_n}} : fsm_rst_n;
  assign bus.dom_clk_en   = bus.test_mode ? '1 : fsm_clk_en;
  assign bus.dom_rst_sts  = fsm_rst_sts;
  assign bus.dom_sleeping = fsm_sleeping;
endmodule

// File: tb/tb_scr1_pwr_seq_ctrl.sv
// tb_scr1_pwr_seq_ctrl: directed stimulus with a cycle-stamped expectation queue checked by a negedge monitor
module tb_scr1_pwr_seq_ctrl;
  localparam int N = 4;
  typedef struct {
    int         at;
    string      nm;
    int         fld;
    logic [N-1:0] v;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t q[$];
  scr1_pwr_seq_ctrl_if #(.DOM_NUM(N)) bus();
  scr1_pwr_seq_ctrl #(
    .DOM_NUM     (N),
    .RST_STAGGER (4),
    .IDLE_THRESH (16),
    .CNT_W       (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [N-1:0] get(int f);
    return f == 0 ? bus.dom_rst_n : f == 1 ? bus.dom_rst_sts : f == 2 ? bus.dom_clk_en : bus.dom_sleeping;
  endfunction
  function automatic void push(int at, string nm, int fld, logic [N-1:0] v);
    q.push_back('{at, nm, fld, v});
  endfunction
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic wait_to(int c);
    while (cyc < c) tick(1);
  endtask
  // monitor: compare every expectation stamped for the cycle just completed
  always @(negedge clk) begin : mon
    exp_t e;
    while (q.size() > 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      vectors++;
      if (e.at < cyc) begin
        miscompares++;
        $display("FAIL %s: missed sample cycle %0d (now %0d)", e.nm, e.at, cyc);
      end else if (get(e.fld) !== e.v) begin
        miscompares++;
        $display("FAIL %s: got %b, expected %b (cycle %0d)", e.nm, get(e.fld), e.v, cyc);
      end
    end
  end
  initial begin
    int e0, r, s, w, x, d, q0, z;
    exp_t lo;
    bus.test_mode = 1'b0;
    bus.dom_rst_req = '0;
    bus.dom_busy = '0;
    bus.dom_sleep_req = '0;
    bus.dom_wake_req = '0;
    tick(3);
    push(cyc, "rst_rst_n", 0, 4'b0000);
    push(cyc, "rst_sts", 1, 4'b1111);
    push(cyc, "rst_clk_en", 2, 4'b1111);
    push(cyc, "rst_sleeping", 3, 4'b0000);
    rst_n = 1'b1;
    e0 = cyc + 1;
    push(e0 + 3, "por_e3", 0, 4'b0000);
    push(e0 + 4, "por_d0", 0, 4'b0001);
    push(e0 + 8, "por_e8", 0, 4'b0001);
    push(e0 + 9, "por_d1", 0, 4'b0011);
    push(e0 + 9, "por_sts_e9", 1, 4'b1100);
    push(e0 + 13, "por_e13", 0, 4'b0011);
    push(e0 + 14, "por_d2", 0, 4'b0111);
    push(e0 + 18, "por_e18", 0, 4'b0111);
    push(e0 + 19, "por_d3", 0, 4'b1111);
    push(e0 + 19, "por_sts", 1, 4'b0000);
    push(e0 + 19, "por_clk_en", 2, 4'b1111);
    wait_to(e0 + 20);
    bus.dom_rst_req = 4'b0010;
    r = cyc + 1;
    tick(1);
    bus.dom_rst_req = '0;
    push(r, "rq_d1", 0, 4'b1101);
    push(r, "rq_sts", 1, 4'b0010);
    push(r + 1, "rq_d2", 0, 4'b1001);
    push(r + 2, "rq_d3", 0, 4'b0001);
    push(r + 4, "rq_r4", 0, 4'b0001);
    push(r + 5, "rq_rel1", 0, 4'b0011);
    push(r + 9, "rq_r9", 0, 4'b0011);
    push(r + 10, "rq_rel2", 0, 4'b0111);
    push(r + 14, "rq_r14", 0, 4'b0111);
    push(r + 15, "rq_rel3", 0, 4'b1111);
    wait_to(r + 16);
    bus.dom_sleep_req = 4'b0100;
    s = cyc + 1;
    push(s + 16, "abort_no_sleep", 2, 4'b1111);
    push(s + 26, "abort_e26", 2, 4'b1111);
    push(s + 27, "slp_clk_en", 2, 4'b1011);
    push(s + 27, "slp_sleeping", 3, 4'b0100);
    wait_to(s + 9);
    bus.dom_busy = 4'b0100;
    tick(1);
    bus.dom_busy = '0;
    wait_to(s + 30);
    bus.dom_wake_req = 4'b0100;
    w = cyc + 1;
    push(w, "wake_clk_en", 2, 4'b1111);
    push(w, "wake_sleeping", 3, 4'b0000);
    push(w + 20, "sleep_wake_run", 2, 4'b1111);
    wait_to(w + 20);
    bus.dom_wake_req = '0;
    x = cyc + 1;
    push(x + 15, "resleep_e15", 2, 4'b1111);
    push(x + 16, "resleep", 2, 4'b1011);
    wait_to(x + 18);
    bus.dom_sleep_req = 4'b1100;
    d = cyc + 1;
    push(d + 16, "d3_sleep_clk_en", 2, 4'b0011);
    push(d + 16, "d3_sleeping", 3, 4'b1100);
    wait_to(d + 18);
    bus.dom_rst_req = 4'b1000;
    q0 = cyc + 1;
    tick(1);
    bus.dom_rst_req = '0;
    push(q0, "d3rq_clk_en", 2, 4'b1011);
    push(q0, "d3rq_rst_n", 0, 4'b0111);
    push(q0, "d3rq_sts", 1, 4'b1000);
    push(q0, "d3rq_sleeping", 3, 4'b0100);
    wait_to(q0 + 2);
    rst_n = 1'b0;
    z = cyc + 1;
    push(z, "midrel_rst_n", 0, 4'b0000);
    push(z, "midrel_sts", 1, 4'b1111);
    push(z, "midrel_clk_en", 2, 4'b1111);
    push(z, "midrel_sleeping", 3, 4'b0000);
    bus.dom_sleep_req = '0;
    tick(2);
    rst_n = 1'b1;
    e0 = cyc + 1;
    push(e0 + 3, "rerel_e3", 0, 4'b0000);
    push(e0 + 4, "rerel_d0", 0, 4'b0001);
    push(e0 + 19, "rerel_all", 0, 4'b1111);
    wait_to(e0 + 20);
    bus.dom_sleep_req = 4'b0010;
    s = cyc + 1;
    push(s + 16, "d1_sleep", 2, 4'b1101);
    wait_to(s + 18);
    bus.test_mode = 1'b1;
    push(cyc, "tm_clk_en", 2, 4'b1111);
    push(cyc, "tm_rst_n", 0, 4'b1111);
    push(cyc, "tm_sleeping", 3, 4'b0010);
    tick(1);
    rst_n = 1'b0;
    push(cyc, "tm_rst_low", 0, 4'b0000);
    push(cyc, "tm_rst_low_clk_en", 2, 4'b1111);
    push(cyc, "tm_noedge_sleeping", 3, 4'b0010);
    tick(1);
    bus.test_mode = 1'b0;
    push(cyc, "post_rst_sleeping", 3, 4'b0000);
    tick(2);
    for (int i = 0; i < 50 && q.size() > 0; i++) tick(1);
    while (q.size() > 0) begin
      lo = q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %s: never checked, expected %b at cycle %0d", lo.nm, lo.v, lo.at);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
